// File: rtl/multicycle_controller_pkg.sv
// mc_ctrl_pkg: state codes, opcodes, datapath select encodings and the control-word type for the multicycle controller.
package mc_ctrl_pkg;
  typedef logic [3:0] stateT;
  localparam stateT FETCH    = 4'h0;
  localparam stateT DECODE   = 4'h1;
  localparam stateT MEMADR   = 4'h2;
  localparam stateT MEMREAD  = 4'h3;
  localparam stateT MEMWB    = 4'h4;
  localparam stateT MEMWRITE = 4'h5;
  localparam stateT EXECUTER = 4'h6;
  localparam stateT EXECUTEI = 4'h7;
  localparam stateT JAL      = 4'h8;
  localparam stateT ALUWB    = 4'h9;
  localparam stateT BEQ      = 4'hA;
  localparam stateT TRAP     = 4'hF;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  typedef struct packed {
    logic       pcUpdate;
    logic       branch;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite;
  } ctrlT;
  // States that touch shared memory and therefore stretch by the wait count.
  function automatic logic isMemState(input stateT s);
    return s == FETCH || s == MEMREAD || s == MEMWRITE;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// mc_ctrl_if: opcode in, datapath selects/strobes out; master is the controller, slave the datapath side.
interface mc_ctrl_if;
  logic [6:0] Op;
  logic       PCUpdate;
  logic       Branch;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] State;
  modport master (
    input  Op,
    output PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, State
  );
  modport slave (
    output Op,
    input  PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, State
  );
endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// imm_src_decoder: combinational opcode -> immediate format select, shared with the single-cycle decoder.
module imm_src_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immSrc
);
  always_comb
    immSrc = op == OP_SW  ? IMM_S :
             op == OP_BEQ ? IMM_B :
             op == OP_JAL ? IMM_J : IMM_I;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback with MEM_LAT memory wait states.
// Define MC_CTRL_ILLEGAL_TRAP_EN to lock unknown opcodes into TRAP until reset instead of treating them as NOPs.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input logic      clk,
  input logic      rst_n,
  mc_ctrl_if.master bus
);
  localparam int CNT_W = MEM_LAT > 0 ? $clog2(MEM_LAT + 1) : 1;
  stateT            state, nextState;
  logic [CNT_W-1:0] cnt;
  logic             waitDone;
  ctrlT             ctrl, ctrlOut;
  assign waitDone = cnt == CNT_W'(MEM_LAT);
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:    nextState = waitDone ? DECODE : FETCH;
      DECODE:
        case (bus.Op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTER;
          OP_I:         nextState = EXECUTEI;
          OP_JAL:       nextState = JAL;
          OP_BEQ:       nextState = BEQ;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      nextState = TRAP;
`else
          default:      nextState = FETCH;
`endif
        endcase
      MEMADR:   nextState = bus.Op == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  nextState = waitDone ? MEMWB : MEMREAD;
      MEMWRITE: nextState = waitDone ? FETCH : MEMWRITE;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      JAL:      nextState = ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      TRAP:     nextState = TRAP;
`endif
      default:  nextState = FETCH;
    endcase
  end
  // Counter idles at 0, so every memory state is entered with a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= (isMemState(state) && !waitDone) ? cnt + CNT_W'(1) : '0;
    end
  end
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALU_ADD;
        ctrl.resultSrc = RES_ALURES;
        ctrl.irWrite   = waitDone;
        ctrl.pcUpdate  = waitDone;
      end
      DECODE: begin
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMADR: begin
        ctrl.aluSrcA = SRCA_RD1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMREAD: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.adrSrc    = 1'b1;
      end
      MEMWB: begin
        ctrl.resultSrc = RES_DATA;
        ctrl.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.adrSrc    = 1'b1;
        ctrl.memWrite  = 1'b1;
      end
      EXECUTER: begin
        ctrl.aluSrcA = SRCA_RD1;
        ctrl.aluSrcB = SRCB_RD2;
        ctrl.aluOp   = ALU_FN;
      end
      EXECUTEI: begin
        ctrl.aluSrcA = SRCA_RD1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_FN;
      end
      JAL: begin
        ctrl.aluSrcA   = SRCA_OLDPC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALU_ADD;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.pcUpdate  = 1'b1;
      end
      ALUWB: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regWrite  = 1'b1;
      end
      BEQ: begin
        ctrl.aluSrcA   = SRCA_RD1;
        ctrl.aluSrcB   = SRCB_RD2;
        ctrl.aluOp     = ALU_SUB;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
  // Reset masks every strobe in the same cycle so an abandoned instruction never writes.
  assign ctrlOut       = rst_n ? ctrl : '0;
  assign bus.PCUpdate  = ctrlOut.pcUpdate;
  assign bus.Branch    = ctrlOut.branch;
  assign bus.AdrSrc    = ctrlOut.adrSrc;
  assign bus.MemWrite  = ctrlOut.memWrite;
  assign bus.IRWrite   = ctrlOut.irWrite;
  assign bus.ResultSrc = ctrlOut.resultSrc;
  assign bus.ALUSrcA   = ctrlOut.aluSrcA;
  assign bus.ALUSrcB   = ctrlOut.aluSrcB;
  assign bus.ALUOp     = ctrlOut.aluOp;
  assign bus.RegWrite  = ctrlOut.regWrite;
  assign bus.State     = state;
  imm_src_decoder immDec (
    .op    (bus.Op),
    .immSrc(bus.ImmSrc)
  );
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle RISC-V control unit and parametrised successor to the single-cycle main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps and drives datapath mux selects and write strobes every cycle. Adds I-type ALU and jal, configurable memory wait states, and optional illegal-opcode trapping. Sits between the instruction register (Op) and the shared-memory multicycle datapath.

Parameters:
MEM_LAT, 0, extra wait cycles per memory access (FETCH, MEMREAD, MEMWRITE); 0..15
CNT_W, $clog2(MEM_LAT+1) min 1, wait-counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
Op  input  7  instruction opcode from IR
PCUpdate  output  1  PC write enable
Branch  output  1  conditional PC write (datapath ANDs with Zero)
AdrSrc  output  1  memory address select: 0=PC, 1=Result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  IR/OldPC load enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=const 4
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
ImmSrc  output  2  combinational from Op: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00
RegWrite  output  1  register file write enable
State  output  4  current state encoding (debug)

Behaviour:
- Reset: state <= FETCH and wait counter <= 0 on any rising edge with rst_n=0. While rst_n=0 all outputs except ImmSrc and State are forced to 0. Mid-instruction reset abandons the instruction; no strobe fires in the reset cycle.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and outputs (unlisted outputs = 0):
  FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=1 only in the final wait cycle -> DECODE
  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 -> lw/sw MEMADR, R EXECUTER, I-ALU EXECUTEI, jal JAL, beq BEQ, other ILLEGAL path
  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> lw MEMREAD, sw MEMWRITE
  MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB after final wait cycle
  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH
  MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 for all MEM_LAT+1 cycles -> FETCH
  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB
  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB
  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB
  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH
  BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH
- Wait counter: loads 0 on entry to a memory state, increments each cycle, exits when it equals MEM_LAT, then clears. MEM_LAT=0 gives one cycle per memory state.
- Cycles per instruction with MEM_LAT=0: lw 5, sw 4, R/I/jal 4, beq 3. Each of FETCH, MEMREAD and MEMWRITE adds MEM_LAT.
- Op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Unused state encodings return to FETCH next cycle with all strobes 0.

Optional Feature:
MC_CTRL_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE moves to TRAP (all strobes 0, State=4'hF) and stays there until reset.
- Undefined: an unknown opcode in DECODE returns to FETCH as a NOP with no writes; the PC has already advanced by 4.

Decomposition:
- Package mc_ctrl_pkg holds the state enum (4-bit), opcode localparams, and ALUOp/ResultSrc/ALUSrc encodings.
- Sub-module imm_src_decoder: combinational Op -> ImmSrc, reused by the single-cycle path.

Test Plan:
- MEM_LAT=0, Op=0000011 after reset: State sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1, ResultSrc=01 only in cycle 5; IRWrite=1 only in cycle 1.
- MEM_LAT=2, Op=0100011: FETCH lasts 3 cycles with IRWrite=1 only in the 3rd; MemWrite=1 for 3 cycles, AdrSrc=1; total 8 cycles back to FETCH.
- Op=1100011: BEQ cycle shows Branch=1, ALUOp=01, ALUSrcA=10, ALUSrcB=00, ImmSrc=10; 3 cycles total.
- Op=1101111 then 0010011: JAL shows PCUpdate=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11, then ALUWB RegWrite=1; EXECUTEI shows ALUSrcB=01, ALUOp=10.
- Op=1111111: with the macro, State=F, strobes 0 for 10+ cycles until rst_n=0 -> FETCH. Without it, back to FETCH after DECODE with no RegWrite or MemWrite.
- rst_n=0 asserted in MEMWRITE with MEM_LAT=3: MemWrite=0 in the reset cycle; FETCH follows with counter restarted at 0.
